// File: rtl/riscv_div_unit_if.sv
// Handshake/result bundle between the EX-stage pipeline and the RV32M divide unit.
// master = pipeline side, slave = divide unit.
interface riscv_div_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            op_div;
    logic [1:0]      funct;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op_div, funct, a, b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, op_div, funct, a, b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/riscv_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per cycle.
// Optional RISCV_DIV_REUSE_EN keeps the last quotient/remainder pair for DIV-then-REM reuse.
module riscv_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input logic             clk,
    input logic             rst,
    riscv_div_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] OneVal  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LastIt = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return ~x + OneVal;
    endfunction

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d;
    logic            qsign_q, qsign_d;
    logic            rsign_q, rsign_d;

`ifdef RISCV_DIV_REUSE_EN
    logic            cache_valid_q, cache_valid_d;
    logic [XLEN-1:0] cache_a_q, cache_a_d;
    logic [XLEN-1:0] cache_b_q, cache_b_d;
    logic            cache_sgn_q, cache_sgn_d;
    logic [XLEN-1:0] cache_quo_q, cache_quo_d;
    logic [XLEN-1:0] cache_rem_q, cache_rem_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic            op_sgn_q, op_sgn_d;
    logic            cache_hit;
`endif

    logic            is_signed;
    logic            accept;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] spec_quo, spec_rem;
    logic [XLEN:0]   shifted, trial;
    logic [XLEN-1:0] step_quo, step_rem;
    logic [XLEN-1:0] fin_quo, fin_rem;

    assign is_signed = ~bus.funct[0];
    assign accept    = (state_q == StIdle) && bus.start && bus.op_div && !bus.flush;
    assign div_zero  = (bus.b == '0);
    assign sgn_ovf   = is_signed && (bus.a == MinNeg) && (bus.b == '1);
    assign a_mag     = (is_signed && bus.a[XLEN-1]) ? neg(bus.a) : bus.a;
    assign b_mag     = (is_signed && bus.b[XLEN-1]) ? neg(bus.b) : bus.b;
    assign spec_quo  = div_zero ? '1 : bus.a;
    assign spec_rem  = div_zero ? bus.a : '0;

`ifdef RISCV_DIV_REUSE_EN
    assign cache_hit = cache_valid_q && (bus.a == cache_a_q) && (bus.b == cache_b_q) &&
                       (is_signed == cache_sgn_q);
`endif

    // Dividend magnitude sits in quo and shifts its MSB into rem each step.
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign trial    = shifted - {1'b0, dvsr_q};
    assign step_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};
    assign fin_quo  = qsign_q ? neg(step_quo) : step_quo;
    assign fin_rem  = rsign_q ? neg(step_rem) : step_rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        is_rem_d = is_rem_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
`ifdef RISCV_DIV_REUSE_EN
        cache_valid_d = cache_valid_q;
        cache_a_d     = cache_a_q;
        cache_b_d     = cache_b_q;
        cache_sgn_d   = cache_sgn_q;
        cache_quo_d   = cache_quo_q;
        cache_rem_d   = cache_rem_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_sgn_d      = op_sgn_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    is_rem_d = bus.funct[1];
                    cnt_d    = '0;
                    if (div_zero || sgn_ovf) begin
                        quo_d    = spec_quo;
                        rem_d    = spec_rem;
                        qsign_d  = 1'b0;
                        rsign_d  = 1'b0;
                        result_d = bus.funct[1] ? spec_rem : spec_quo;
                        state_d  = StDone;
`ifdef RISCV_DIV_REUSE_EN
                        cache_valid_d = 1'b1;
                        cache_a_d     = bus.a;
                        cache_b_d     = bus.b;
                        cache_sgn_d   = is_signed;
                        cache_quo_d   = spec_quo;
                        cache_rem_d   = spec_rem;
                    end else if (cache_hit) begin
                        result_d = bus.funct[1] ? cache_rem_q : cache_quo_q;
                        state_d  = StDone;
`endif
                    end else begin
                        quo_d   = a_mag;
                        rem_d   = '0;
                        dvsr_d  = b_mag;
                        qsign_d = is_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                        rsign_d = is_signed && bus.a[XLEN-1];
                        state_d = StCalc;
`ifdef RISCV_DIV_REUSE_EN
                        cache_valid_d = 1'b0;
                        op_a_d        = bus.a;
                        op_b_d        = bus.b;
                        op_sgn_d      = is_signed;
`endif
                    end
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q + CntOne;
                    if (cnt_q == LastIt) begin
                        quo_d    = fin_quo;
                        rem_d    = fin_rem;
                        result_d = is_rem_q ? fin_rem : fin_quo;
                        state_d  = StDone;
`ifdef RISCV_DIV_REUSE_EN
                        cache_valid_d = 1'b1;
                        cache_a_d     = op_a_q;
                        cache_b_d     = op_b_q;
                        cache_sgn_d   = op_sgn_q;
                        cache_quo_d   = fin_quo;
                        cache_rem_d   = fin_rem;
`endif
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef RISCV_DIV_REUSE_EN
        if (bus.flush) begin
            cache_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            is_rem_q <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
`ifdef RISCV_DIV_REUSE_EN
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_sgn_q   <= 1'b0;
            cache_quo_q   <= '0;
            cache_rem_q   <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_sgn_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            is_rem_q <= is_rem_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
`ifdef RISCV_DIV_REUSE_EN
            cache_valid_q <= cache_valid_d;
            cache_a_q     <= cache_a_d;
            cache_b_q     <= cache_b_d;
            cache_sgn_q   <= cache_sgn_d;
            cache_quo_q   <= cache_quo_d;
            cache_rem_q   <= cache_rem_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_sgn_q      <= op_sgn_d;
`endif
        end
    end

    // Accept-cycle stall term is combinational so upstream freezes on the request itself.
    assign bus.stall  = ((state_q == StIdle) && bus.start && bus.op_div && !bus.flush) ||
                        (state_q == StCalc);
    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone) && !bus.flush;
    assign bus.result = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Randomized self-checking bench for riscv_div_unit against a plain-arithmetic reference.
module tb_riscv_div_unit;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    riscv_div_unit_if #(.XLEN(XLEN)) bus ();

    riscv_div_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reuse-cache model: last completed operands and signedness.
    bit          m_valid = 1'b0;
    logic [31:0] m_a     = '0;
    logic [31:0] m_b     = '0;
    bit          m_sgn   = 1'b0;
    logic [31:0] last_res = '0;

    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return f[1] ? r : q;
    endfunction

    function automatic int ref_latency(input logic [1:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RISCV_DIV_REUSE_EN
        if (m_valid && a == m_a && b == m_b && m_sgn == !f[0]) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Issue one op starting just after a clock edge; returns observations, no checking.
    task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int exp_lat,
                         output int stall_err, output logic done_after,
                         output logic [31:0] res_after);
        exp_lat    = ref_latency(f, a, b);
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
        bus.funct  = f;
        bus.a      = a;
        bus.b      = b;
        bus.flush  = 1'b0;
        #1;
        stall_err = (bus.stall !== 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.op_div = 1'b0;
        bus.a      = $urandom;
        bus.b      = $urandom;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                if (bus.stall !== 1'b0) stall_err++;
                break;
            end
            if (c < exp_lat && bus.stall !== 1'b1) stall_err++;
            @(posedge clk);
            #1;
        end
        res = bus.result;
        @(posedge clk);
        #1;
        done_after = bus.done;
        res_after  = bus.result;
        m_valid  = 1'b1;
        m_a      = a;
        m_b      = b;
        m_sgn    = !f[0];
        last_res = ref_result(f, a, b);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op_div = 1'b0; bus.funct = 2'b00;
        bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        rst = 1'b0;
        #12;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", bus.stall); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done); end
        n_tests++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  tf [7];
        logic [31:0] ta [7];
        logic [31:0] tbv[7];
        logic [31:0] te [7];
        logic [31:0] res, res_after;
        int lat, exp_lat, serr;
        logic done_after;
        tf[0] = 2'b01; ta[0] = 32'd100;        tbv[0] = 32'd7;          te[0] = 32'd14;
        tf[1] = 2'b10; ta[1] = 32'hFFFF_FFF9;  tbv[1] = 32'd2;          te[1] = 32'hFFFF_FFFF;
        tf[2] = 2'b00; ta[2] = 32'hFFFF_FFF9;  tbv[2] = 32'd2;          te[2] = 32'hFFFF_FFFD;
        tf[3] = 2'b00; ta[3] = 32'd5;          tbv[3] = 32'd0;          te[3] = 32'hFFFF_FFFF;
        tf[4] = 2'b11; ta[4] = 32'd5;          tbv[4] = 32'd0;          te[4] = 32'd5;
        tf[5] = 2'b00; ta[5] = 32'h8000_0000;  tbv[5] = 32'hFFFF_FFFF;  te[5] = 32'h8000_0000;
        tf[6] = 2'b10; ta[6] = 32'h8000_0000;  tbv[6] = 32'hFFFF_FFFF;  te[6] = 32'd0;
        for (int i = 0; i < 7; i++) begin
            do_op(tf[i], ta[i], tbv[i], res, lat, exp_lat, serr, done_after, res_after);
            n_tests++; if (res !== te[i]) begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, res, te[i]); end
            n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat); end
            n_tests++; if (serr != 0) begin n_fail++; $display("FAIL dir%0d_stall got %0d bad cycles want 0", i, serr); end
            n_tests++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got %0b want 0", i, done_after); end
            n_tests++; if (res_after !== te[i]) begin n_fail++; $display("FAIL dir%0d_hold got %h want %h", i, res_after, te[i]); end
        end
    endtask

    task automatic test_reuse();
        logic [1:0]  tf [3];
        logic [31:0] tbv[3];
        logic [31:0] te [3];
        logic [31:0] res, res_after;
        int lat, exp_lat, serr;
        logic done_after;
        tf[0] = 2'b00; tbv[0] = 32'd7; te[0] = 32'd14;
        tf[1] = 2'b10; tbv[1] = 32'd7; te[1] = 32'd2;
        tf[2] = 2'b10; tbv[2] = 32'd8; te[2] = 32'd4;
        for (int i = 0; i < 3; i++) begin
            do_op(tf[i], 32'd100, tbv[i], res, lat, exp_lat, serr, done_after, res_after);
            n_tests++; if (res !== te[i]) begin n_fail++; $display("FAIL reuse%0d_result got %h want %h", i, res, te[i]); end
            n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL reuse%0d_latency got %0d want %0d", i, lat, exp_lat); end
            n_tests++; if (serr != 0) begin n_fail++; $display("FAIL reuse%0d_stall got %0d bad cycles want 0", i, serr); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev, res, res_after;
        int lat, exp_lat, serr, done_seen;
        logic done_after;
        prev = last_res;
        bus.start = 1'b1; bus.op_div = 1'b1; bus.funct = 2'b01;
        bus.a = 32'd1000; bus.b = 32'd3; bus.flush = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_div = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        #1;
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL flush_calc_stall got %0b want 1", bus.stall); end
        @(posedge clk); #1;
        m_valid = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %0b want 0", bus.busy); end
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %0b want 0", bus.stall); end
        n_tests++; if (bus.result !== prev) begin n_fail++; $display("FAIL flush_result got %h want %h", bus.result, prev); end
        bus.flush = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL flush_no_done got %0d pulses want 0", done_seen); end
        // flush together with start in IDLE must not accept
        bus.start = 1'b1; bus.op_div = 1'b1; bus.flush = 1'b1;
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_start_stall got %0b want 0", bus.stall); end
        @(posedge clk); #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got %0b want 0", bus.busy); end
        // start without op_div must not accept
        bus.flush = 1'b0; bus.op_div = 1'b0;
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL noop_stall got %0b want 0", bus.stall); end
        @(posedge clk); #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL noop_busy got %0b want 0", bus.busy); end
        bus.start = 1'b0;
        do_op(2'b01, 32'd1000, 32'd3, res, lat, exp_lat, serr, done_after, res_after);
        n_tests++; if (res !== 32'd333) begin n_fail++; $display("FAIL after_flush_result got %h want %h", res, 32'd333); end
        n_tests++; if (lat != XLEN + 1) begin n_fail++; $display("FAIL after_flush_latency got %0d want %0d", lat, XLEN + 1); end
    endtask

    task automatic test_busy_start();
        int lat;
        bus.start = 1'b1; bus.op_div = 1'b1; bus.funct = 2'b00;
        bus.a = 32'd1000; bus.b = 32'd3; bus.flush = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_div = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op_div = 1'b1; bus.funct = 2'b11;
        bus.a = 32'd77; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_div = 1'b0;
        lat = -1;
        for (int c = 6; c <= 60; c++) begin
            if (bus.done === 1'b1) begin lat = c; break; end
            @(posedge clk); #1;
        end
        n_tests++; if (lat != XLEN + 1) begin n_fail++; $display("FAIL busy_start_latency got %0d want %0d", lat, XLEN + 1); end
        n_tests++; if (bus.result !== 32'd333) begin n_fail++; $display("FAIL busy_start_result got %h want %h", bus.result, 32'd333); end
        m_valid = 1'b1; m_a = 32'd1000; m_b = 32'd3; m_sgn = 1'b1; last_res = 32'd333;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res, res_after;
        int lat, exp_lat, serr;
        logic done_after;
        bus.start = 1'b1; bus.op_div = 1'b1; bus.funct = 2'b01;
        bus.a = 32'd12345; bus.b = 32'd67; bus.flush = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op_div = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %0b want 0", bus.busy); end
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %0b want 0", bus.stall); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %0b want 0", bus.done); end
        n_tests++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", bus.result); end
        m_valid = 1'b0; last_res = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_op(2'b01, 32'd12345, 32'd67, res, lat, exp_lat, serr, done_after, res_after);
        n_tests++; if (res !== 32'd184) begin n_fail++; $display("FAIL rst_recover_result got %h want %h", res, 32'd184); end
        n_tests++; if (lat != XLEN + 1) begin n_fail++; $display("FAIL rst_recover_latency got %0d want %0d", lat, XLEN + 1); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, exp, res, res_after, pa, pb;
        logic [1:0]  f;
        int lat, exp_lat, serr, sel;
        logic done_after;
        pa = 32'd1; pb = 32'd1;
        for (int i = 0; i < 40; i++) begin
            f   = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            case (sel)
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = pa; b = pb; end
                3, 4: begin a = $urandom_range(0, 300) - 150; b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            exp = ref_result(f, a, b);
            do_op(f, a, b, res, lat, exp_lat, serr, done_after, res_after);
            n_tests++; if (res !== exp) begin n_fail++; $display("FAIL rand%0d_result f=%0d a=%h b=%h got %h want %h", i, f, a, b, res, exp); end
            n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, exp_lat); end
            pa = a; pb = b;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reuse();
        test_flush();
        test_busy_start();
        test_reset_mid_calc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Multi-cycle RV32M divide/remainder unit in the EX stage.
- Executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle.
- Drives the stall input of the IF/ID, ID/EX and EX/MEM pipeline registers while busy.
- Returns the result with a one-cycle done pulse, which the pipeline captures when it resumes.

Parameters:
- XLEN, 32, operand/result width; also the iteration count.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  request from decode/EX; qualified by op_div
- op_div  in  1  instruction is a divide-class op
- funct  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- a  in  XLEN  dividend (rs1)
- b  in  XLEN  divisor (rs2)
- flush  in  1  branch/exception kill of the in-flight op
- stall  out  1  hold upstream pipeline registers
- busy  out  1  FSM not IDLE
- done  out  1  result valid this cycle, single-cycle pulse
- result  out  XLEN  quotient or remainder

Behaviour:
- Reset (rst=0, async): state=IDLE; counter=0; quotient, remainder, divisor and result registers=0; done=0; busy=0.
- States: IDLE, CALC, DONE.
- Accept condition: start && op_div && state==IDLE && !flush, sampled at edge E0.
- Accept path for the general case:
  - latch funct;
  - latch |a| and |b| (magnitudes taken only when signed);
  - latch quotient sign = a[XLEN-1]^b[XLEN-1] and remainder sign = a[XLEN-1], both signed only;
  - go to CALC with counter=0.
- Special cases, resolved at accept; go directly to DONE with no CALC cycles:
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow (a==1<<(XLEN-1), b==all ones): quotient = a; remainder = 0.
- CALC step, once per cycle:
  - {rem,quo} shifted left 1;
  - trial = rem - divisor, computed XLEN+1 bits wide;
  - if trial is non-negative, rem = trial and quo[0] = 1.
  - counter++; after XLEN steps, go to DONE.
- Sign fix-up on entry to DONE:
  - negate the quotient if its sign bit is set;
  - negate the remainder if its sign bit is set;
  - result = quotient for DIV/DIVU, remainder for REM/REMU.
- DONE: done=1 for exactly one cycle, then IDLE. result holds its value until the next accept.
- Latency, accept at E0:
  - general case: done high in cycle XLEN+1 (cycle 33 for XLEN=32);
  - special cases: done high in cycle 1.
- stall = (state==IDLE && start && op_div && !flush) || state==CALC. The first term is combinational, so upstream registers freeze in the accept cycle. stall is 0 in DONE so the pipeline advances and captures result.
- busy = state!=IDLE.
- start while busy: ignored; no state change.
- flush:
  - any state → IDLE next edge; done is suppressed; result is unchanged.
  - flush and start in the same IDLE cycle: no accept.
  - stall deasserts combinationally when flush is asserted in IDLE; it deasserts from the next cycle when flush is asserted in CALC.
- Reset mid-CALC: immediate IDLE, all outputs 0.

Optional Feature:
- Macro: RISCV_DIV_REUSE_EN.
- Defined:
  - keep the last completed operands a, b, the signedness and both final quotient and remainder;
  - an accept whose a, b and signedness match, with a valid cache, goes straight to DONE (done in cycle 1, stall only in the accept cycle) and selects quotient or remainder per funct.
  - Covers the DIV followed by REM idiom.
  - Cache is invalidated by reset, by flush, and by any accept that misses.
- Undefined:
  - no cache storage;
  - every non-special op takes the full XLEN+1 cycles.

Test Plan:
- DIVU a=100, b=7 → stall high for cycles 0..32; done in cycle 33 with result=14; result stays 14 afterwards.
- REM a=-7 (0xFFFFFFF9), b=2 → result=0xFFFFFFFF (-1). DIV with the same operands → 0xFFFFFFFD (-3).
- DIV a=5, b=0 → done in cycle 1 with result=0xFFFFFFFF. REMU a=5, b=0 → 5. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Start DIVU 1000/3, assert flush at cycle 10 → IDLE at cycle 11; stall low from cycle 11; no done pulse; result unchanged. A new start is then accepted normally.
- Start during CALC with different operands → ignored; original result (e.g. 333) returned. Assert rst low mid-CALC → all outputs 0 asynchronously.
- With RISCV_DIV_REUSE_EN: DIV 100/7 then REM 100/7 → second op gives done in cycle 1 with result=2. REM 100/8 → full latency, result=4.
